// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the ID/EX stage.
// The EX control bundle travels as one struct so a bubble is a single constant.
package pipe_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic              valid;
        logic              EscReg;   // active-low register write enable
        logic              MemLe;
        logic [REG_AW-1:0] rd;
    } ex_ctrl_t;

    localparam ex_ctrl_t BUBBLE_CTRL = '{valid: 1'b0, EscReg: 1'b1, MemLe: 1'b0, rd: '0};

    function automatic logic isRealReg(input logic [REG_AW-1:0] r);
        return (r != '0);
    endfunction

endpackage

// File: rtl/operand_mux.sv
// Per-operand source select: EX > MEM > WB > register file, with x0 forced to zero.
// The forwarding unit does not mask x0, so the mask lives here.
module operand_mux #(
    parameter int XLEN   = pipe_pkg::XLEN,
    parameter int REG_AW = pipe_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [XLEN-1:0]   rfData,
    input  logic              fwdEX,
    input  logic              fwdMEM,
    input  logic              fwdWB,
    input  logic [XLEN-1:0]   dataEX,
    input  logic [XLEN-1:0]   dataMEM,
    input  logic [XLEN-1:0]   dataWB,
    output logic [XLEN-1:0]   operand
);

    always_comb begin
        operand = rfData;
        if (rs == '0) begin
            operand = '0;
        end else if (fwdEX) begin
            operand = dataEX;
        end else if (fwdMEM) begin
            operand = dataMEM;
        end else if (fwdWB) begin
            operand = dataWB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding select and load-use stall/bubble.
// Optional ID_EX_STALL_CNT_EN adds stall_cnt / flush_cnt event counters.
module id_ex_stage #(
    parameter int XLEN   = pipe_pkg::XLEN,
    parameter int REG_AW = pipe_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              flush_in,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd_in,
    input  logic              EscReg_in,
    input  logic              MemLe_in,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [XLEN-1:0]   imm_in,
    input  logic              forwardingRs1EX,
    input  logic              forwardingRs2EX,
    input  logic              forwardingRs1MEM,
    input  logic              forwardingRs2MEM,
    input  logic              forwardingRs1WB,
    input  logic              forwardingRs2WB,
    input  logic [XLEN-1:0]   dataEX,
    input  logic [XLEN-1:0]   dataMEM,
    input  logic [XLEN-1:0]   dataWB,
    output logic              stall_out,
    output logic              valid_out,
    output logic [XLEN-1:0]   opA,
    output logic [XLEN-1:0]   opB,
    output logic [XLEN-1:0]   imm_out,
    output logic [REG_AW-1:0] rd_out,
    output logic              EscReg_out,
    output logic              MemLe_out
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    import pipe_pkg::*;

    logic [REG_AW-1:0] srcIdx  [2];
    logic [XLEN-1:0]   srcData [2];
    logic              srcEX   [2];
    logic              srcMEM  [2];
    logic              srcWB   [2];
    logic [XLEN-1:0]   selOp   [2];

    assign srcIdx[0]  = rs1;
    assign srcIdx[1]  = rs2;
    assign srcData[0] = rs1_data;
    assign srcData[1] = rs2_data;
    assign srcEX[0]   = forwardingRs1EX;
    assign srcEX[1]   = forwardingRs2EX;
    assign srcMEM[0]  = forwardingRs1MEM;
    assign srcMEM[1]  = forwardingRs2MEM;
    assign srcWB[0]   = forwardingRs1WB;
    assign srcWB[1]   = forwardingRs2WB;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opmux
            operand_mux #(
                .XLEN   (XLEN),
                .REG_AW (REG_AW)
            ) u_mux (
                .rs      (srcIdx[gi]),
                .rfData  (srcData[gi]),
                .fwdEX   (srcEX[gi]),
                .fwdMEM  (srcMEM[gi]),
                .fwdWB   (srcWB[gi]),
                .dataEX  (dataEX),
                .dataMEM (dataMEM),
                .dataWB  (dataWB),
                .operand (selOp[gi])
            );
        end
    endgenerate

    ex_ctrl_t          exCtrl_reg,  exCtrl_next;
    logic [XLEN-1:0]   opA_reg,     opA_next;
    logic [XLEN-1:0]   opB_reg,     opB_next;
    logic [XLEN-1:0]   imm_reg,     imm_next;
    logic              hazard;

    // An EX flag against a valid load means the data is not ready until MEM.
    assign hazard = valid_in & exCtrl_reg.MemLe & exCtrl_reg.valid &
                    ((forwardingRs1EX & isRealReg(rs1)) | (forwardingRs2EX & isRealReg(rs2)));

    assign stall_out = hazard & ~flush_in;

    always_comb begin
        exCtrl_next = BUBBLE_CTRL;
        opA_next    = '0;
        opB_next    = '0;
        imm_next    = '0;
        if (!flush_in && !hazard && valid_in) begin
            exCtrl_next.valid  = 1'b1;
            exCtrl_next.EscReg = EscReg_in;
            exCtrl_next.MemLe  = MemLe_in;
            exCtrl_next.rd     = rd_in;
            opA_next           = selOp[0];
            opB_next           = selOp[1];
            imm_next           = imm_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exCtrl_reg <= BUBBLE_CTRL;
            opA_reg    <= '0;
            opB_reg    <= '0;
            imm_reg    <= '0;
        end else begin
            exCtrl_reg <= exCtrl_next;
            opA_reg    <= opA_next;
            opB_reg    <= opB_next;
            imm_reg    <= imm_next;
        end
    end

    assign valid_out  = exCtrl_reg.valid;
    assign EscReg_out = exCtrl_reg.EscReg;
    assign MemLe_out  = exCtrl_reg.MemLe;
    assign rd_out     = exCtrl_reg.rd;
    assign opA        = opA_reg;
    assign opB        = opB_reg;
    assign imm_out    = imm_reg;

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stallCnt_reg;
    logic [31:0] flushCnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt_reg <= '0;
            flushCnt_reg <= '0;
        end else begin
            if (stall_out) begin
                stallCnt_reg <= stallCnt_reg + 32'd1;
            end
            if (flush_in && valid_in) begin
                flushCnt_reg <= flushCnt_reg + 32'd1;
            end
        end
    end

    assign stall_cnt = stallCnt_reg;
    assign flush_cnt = flushCnt_reg;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX state is queued when ID is driven
// and compared one edge later; counters are checked when ID_EX_STALL_CNT_EN is defined.
module tb_id_ex_stage;

    localparam int XL = 32;
    localparam int AW = 5;
    localparam int EW = 3 + AW + 3 * XL;
    localparam logic [EW-1:0] BUBBLE = {1'b0, 1'b1, 1'b0, {AW{1'b0}}, {(3 * XL){1'b0}}};

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in, flush_in;
    logic [AW-1:0] rs1, rs2, rd_in;
    logic          EscReg_in, MemLe_in;
    logic [XL-1:0] rs1_data, rs2_data, imm_in;
    logic          forwardingRs1EX, forwardingRs2EX, forwardingRs1MEM;
    logic          forwardingRs2MEM, forwardingRs1WB, forwardingRs2WB;
    logic [XL-1:0] dataEX, dataMEM, dataWB;
    logic          stall_out, valid_out, EscReg_out, MemLe_out;
    logic [XL-1:0] opA, opB, imm_out;
    logic [AW-1:0] rd_out;
`ifdef ID_EX_STALL_CNT_EN
    logic [31:0]   stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XL), .REG_AW(AW)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .flush_in(flush_in),
        .rs1(rs1), .rs2(rs2), .rd_in(rd_in), .EscReg_in(EscReg_in), .MemLe_in(MemLe_in),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm_in(imm_in),
        .forwardingRs1EX(forwardingRs1EX), .forwardingRs2EX(forwardingRs2EX),
        .forwardingRs1MEM(forwardingRs1MEM), .forwardingRs2MEM(forwardingRs2MEM),
        .forwardingRs1WB(forwardingRs1WB), .forwardingRs2WB(forwardingRs2WB),
        .dataEX(dataEX), .dataMEM(dataMEM), .dataWB(dataWB),
        .stall_out(stall_out), .valid_out(valid_out), .opA(opA), .opB(opB),
        .imm_out(imm_out), .rd_out(rd_out), .EscReg_out(EscReg_out), .MemLe_out(MemLe_out)
`ifdef ID_EX_STALL_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    logic [EW-1:0] obs;
    assign obs = {valid_out, EscReg_out, MemLe_out, rd_out, opA, opB, imm_out};

    logic [EW-1:0] expQ [$];
    logic [EW-1:0] expV;
    int nChecks = 0;
    int nFail   = 0;

    function automatic logic [EW-1:0] mkExp(input logic v, input logic e, input logic m,
                                            input logic [AW-1:0] rd, input logic [XL-1:0] a,
                                            input logic [XL-1:0] b, input logic [XL-1:0] i);
        return {v, e, m, rd, a, b, i};
    endfunction

    task automatic idle();
        rst = 1'b0; valid_in = 1'b0; flush_in = 1'b0;
        rs1 = '0; rs2 = '0; rd_in = '0; EscReg_in = 1'b1; MemLe_in = 1'b0;
        rs1_data = '0; rs2_data = '0; imm_in = '0;
        forwardingRs1EX = 1'b0; forwardingRs2EX = 1'b0; forwardingRs1MEM = 1'b0;
        forwardingRs2MEM = 1'b0; forwardingRs1WB = 1'b0; forwardingRs2WB = 1'b0;
        dataEX = '0; dataMEM = '0; dataWB = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives a load to register r into EX, with no dependencies of its own.
    task automatic putLoad(input logic [AW-1:0] r);
        idle();
        valid_in = 1'b1; MemLe_in = 1'b1; EscReg_in = 1'b0; rd_in = r;
        rs1 = 5'd1; rs1_data = 32'h10;
        #1;
        nChecks++;
        if (stall_out !== 1'b0) begin
            nFail++; $display("FAIL load_issue_stall: got %b expected 0", stall_out);
        end
        expQ.push_back(mkExp(1'b1, 1'b0, 1'b1, r, 32'h10, 32'h0, 32'h0));
        step();
        expV = expQ.pop_front();
        nChecks++;
        if (obs !== expV) begin
            nFail++; $display("FAIL load_issue: got %h expected %h", obs, expV);
        end else $display("txn load x%0d issued", r);
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            expQ.push_back(BUBBLE);
            step();
            expV = expQ.pop_front();
            nChecks++;
            if (obs !== expV) begin
                nFail++; $display("FAIL reset_state: got %h expected %h", obs, expV);
            end else $display("txn reset cycle %0d bubble", k);
        end
        rst = 1'b0;
        #1;
        nChecks++;
        if (stall_out !== 1'b0) begin
            nFail++; $display("FAIL reset_stall: got %b expected 0", stall_out);
        end
        expQ.push_back(BUBBLE);
        step();
        expV = expQ.pop_front();
        nChecks++;
        if (obs !== expV) begin
            nFail++; $display("FAIL reset_idle: got %h expected %h", obs, expV);
        end else $display("txn idle after reset bubble");
    endtask

    task automatic test_priority();
        logic [XL-1:0] ea, eb;
        idle();
        valid_in = 1'b1; rs1 = 5'd5; rs1_data = 32'h44; rs2 = 5'd3; rs2_data = 32'h55;
        rd_in = 5'd9; EscReg_in = 1'b0; imm_in = 32'h7;
        dataEX = 32'h11; dataMEM = 32'h22; dataWB = 32'h33;
        for (int k = 0; k < 4; k++) begin
            forwardingRs1EX  = (k == 0);
            forwardingRs1MEM = (k <= 1);
            forwardingRs1WB  = (k <= 2);
            forwardingRs2EX  = (k == 2);
            forwardingRs2WB  = (k >= 2);
            ea = (k == 0) ? 32'h11 : (k == 1) ? 32'h22 : (k == 2) ? 32'h33 : 32'h44;
            eb = (k == 2) ? 32'h11 : (k == 3) ? 32'h33 : 32'h55;
            expQ.push_back(mkExp(1'b1, 1'b0, 1'b0, 5'd9, ea, eb, 32'h7));
            step();
            expV = expQ.pop_front();
            nChecks++;
            if (obs !== expV) begin
                nFail++; $display("FAIL priority_%0d: got %h expected %h", k, obs, expV);
            end else $display("txn priority %0d opA=%h opB=%h", k, opA, opB);
        end
    endtask

    task automatic test_x0_mask();
        idle();
        valid_in = 1'b1; EscReg_in = 1'b0; rd_in = 5'd4; imm_in = 32'h100;
        rs1 = 5'd0; rs1_data = 32'h77; forwardingRs1MEM = 1'b1; dataMEM = 32'hBEEF;
        rs2 = 5'd0; rs2_data = 32'h5; forwardingRs2EX = 1'b1; dataEX = 32'hDEAD;
        expQ.push_back(mkExp(1'b1, 1'b0, 1'b0, 5'd4, 32'h0, 32'h0, 32'h100));
        step();
        expV = expQ.pop_front();
        nChecks++;
        if (obs !== expV) begin
            nFail++; $display("FAIL x0_mask: got %h expected %h", obs, expV);
        end else $display("txn x0 mask opA=%h opB=%h", opA, opB);
    endtask

    task automatic test_load_use();
        putLoad(5'd7);
        idle();
        valid_in = 1'b1; rs1 = 5'd7; forwardingRs1EX = 1'b1; dataEX = 32'h999;
        rs1_data = 32'h1; rd_in = 5'd8; EscReg_in = 1'b0; imm_in = 32'h8;
        #1;
        nChecks++;
        if (stall_out !== 1'b1) begin
            nFail++; $display("FAIL loaduse_stall: got %b expected 1", stall_out);
        end
        expQ.push_back(BUBBLE);
        step();
        expV = expQ.pop_front();
        nChecks++;
        if (obs !== expV) begin
            nFail++; $display("FAIL loaduse_bubble: got %h expected %h", obs, expV);
        end else $display("txn load-use bubble");
        forwardingRs1EX = 1'b0; forwardingRs1MEM = 1'b1; dataMEM = 32'hABCD;
        #1;
        nChecks++;
        if (stall_out !== 1'b0) begin
            nFail++; $display("FAIL loaduse_release: got %b expected 0", stall_out);
        end
        expQ.push_back(mkExp(1'b1, 1'b0, 1'b0, 5'd8, 32'hABCD, 32'h0, 32'h8));
        step();
        expV = expQ.pop_front();
        nChecks++;
        if (obs !== expV) begin
            nFail++; $display("FAIL loaduse_mem: got %h expected %h", obs, expV);
        end else $display("txn load-use replay opA=%h", opA);
    endtask

    task automatic test_back_to_back();
        putLoad(5'd7);
        // Dependent load x8 <- [x7], then consumer of x8 on rs2, each stalls once.
        for (int k = 0; k < 2; k++) begin
            idle();
            valid_in = 1'b1; EscReg_in = 1'b0;
            if (k == 0) begin
                MemLe_in = 1'b1; rd_in = 5'd8; rs1 = 5'd7; forwardingRs1EX = 1'b1;
            end else begin
                rd_in = 5'd9; rs2 = 5'd8; forwardingRs2EX = 1'b1;
            end
            #1;
            nChecks++;
            if (stall_out !== 1'b1) begin
                nFail++; $display("FAIL b2b_stall_%0d: got %b expected 1", k, stall_out);
            end
            expQ.push_back(BUBBLE);
            step();
            expV = expQ.pop_front();
            nChecks++;
            if (obs !== expV) begin
                nFail++; $display("FAIL b2b_bubble_%0d: got %h expected %h", k, obs, expV);
            end else $display("txn b2b %0d bubble", k);
            forwardingRs1EX = 1'b0; forwardingRs2EX = 1'b0;
            if (k == 0) forwardingRs1MEM = 1'b1; else forwardingRs2MEM = 1'b1;
            dataMEM = (k == 0) ? 32'h70 : 32'h80;
            if (k == 0) expQ.push_back(mkExp(1'b1, 1'b0, 1'b1, 5'd8, 32'h70, 32'h0, 32'h0));
            else        expQ.push_back(mkExp(1'b1, 1'b0, 1'b0, 5'd9, 32'h0, 32'h80, 32'h0));
            step();
            expV = expQ.pop_front();
            nChecks++;
            if (obs !== expV) begin
                nFail++; $display("FAIL b2b_replay_%0d: got %h expected %h", k, obs, expV);
            end else $display("txn b2b %0d replay", k);
        end
        // A load in EX with an unmasked x0 EX flag is not a hazard.
        putLoad(5'd5);
        idle();
        valid_in = 1'b1; EscReg_in = 1'b0; rd_in = 5'd6; rs1 = 5'd0; forwardingRs1EX = 1'b1;
        rs1_data = 32'h3; dataEX = 32'h4;
        #1;
        nChecks++;
        if (stall_out !== 1'b0) begin
            nFail++; $display("FAIL x0_nohazard: got %b expected 0", stall_out);
        end
        expQ.push_back(mkExp(1'b1, 1'b0, 1'b0, 5'd6, 32'h0, 32'h0, 32'h0));
        step();
        expV = expQ.pop_front();
        nChecks++;
        if (obs !== expV) begin
            nFail++; $display("FAIL x0_nohazard_reg: got %h expected %h", obs, expV);
        end else $display("txn x0 after load, no stall");
    endtask

    task automatic test_flush();
        putLoad(5'd7);
        idle();
        valid_in = 1'b1; flush_in = 1'b1; rs1 = 5'd7; forwardingRs1EX = 1'b1;
        rd_in = 5'd8; EscReg_in = 1'b0;
        #1;
        nChecks++;
        if (stall_out !== 1'b0) begin
            nFail++; $display("FAIL flush_hazard_stall: got %b expected 0", stall_out);
        end
        expQ.push_back(BUBBLE);
        step();
        expV = expQ.pop_front();
        nChecks++;
        if (obs !== expV) begin
            nFail++; $display("FAIL flush_hazard_bubble: got %h expected %h", obs, expV);
        end else $display("txn flush over hazard bubble");
        idle();
        valid_in = 1'b1; rs1 = 5'd2; rs1_data = 32'h20; rd_in = 5'd3; EscReg_in = 1'b0;
        expQ.push_back(mkExp(1'b1, 1'b0, 1'b0, 5'd3, 32'h20, 32'h0, 32'h0));
        step();
        expV = expQ.pop_front();
        nChecks++;
        if (obs !== expV) begin
            nFail++; $display("FAIL flush_next: got %h expected %h", obs, expV);
        end else $display("txn instruction after flush");
        for (int k = 0; k < 2; k++) begin
            flush_in = 1'b1; valid_in = (k == 0);
            expQ.push_back(BUBBLE);
            step();
            expV = expQ.pop_front();
            nChecks++;
            if (obs !== expV) begin
                nFail++; $display("FAIL flush_plain_%0d: got %h expected %h", k, obs, expV);
            end else $display("txn flush %0d bubble", k);
        end
    endtask

    task automatic test_stale_flags();
        putLoad(5'd7);
        idle();
        rs1 = 5'd7; forwardingRs1EX = 1'b1; rs2 = 5'd7; forwardingRs2EX = 1'b1;
        #1;
        nChecks++;
        if (stall_out !== 1'b0) begin
            nFail++; $display("FAIL stale_stall: got %b expected 0", stall_out);
        end
        expQ.push_back(BUBBLE);
        step();
        expV = expQ.pop_front();
        nChecks++;
        if (obs !== expV) begin
            nFail++; $display("FAIL stale_bubble: got %h expected %h", obs, expV);
        end else $display("txn invalid ID with stale flags");
    endtask

    task automatic test_counters();
`ifdef ID_EX_STALL_CNT_EN
        nChecks++;
        if (stall_cnt !== 32'd3) begin
            nFail++; $display("FAIL stall_cnt: got %0d expected 3", stall_cnt);
        end
        nChecks++;
        if (flush_cnt !== 32'd2) begin
            nFail++; $display("FAIL flush_cnt: got %0d expected 2", flush_cnt);
        end
        $display("txn counters stall=%0d flush=%0d", stall_cnt, flush_cnt);
`endif
    endtask

    task automatic test_reset_mid_stall();
        putLoad(5'd7);
        idle();
        valid_in = 1'b1; rs1 = 5'd7; forwardingRs1EX = 1'b1; rd_in = 5'd8; EscReg_in = 1'b0;
        rst = 1'b1;
        expQ.push_back(BUBBLE);
        step();
        expV = expQ.pop_front();
        nChecks++;
        if (obs !== expV) begin
            nFail++; $display("FAIL reset_mid_stall: got %h expected %h", obs, expV);
        end else $display("txn reset during stall");
`ifdef ID_EX_STALL_CNT_EN
        nChecks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            nFail++; $display("FAIL cnt_reset: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
        end
`endif
        idle();
    endtask

    task automatic test_random();
        logic [XL-1:0] ea, eb;
        idle();
        for (int k = 0; k < 24; k++) begin
            valid_in = 1'b1; EscReg_in = 1'($urandom_range(0, 1));
            rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
            rd_in = 5'($urandom_range(0, 31)); imm_in = $urandom;
            rs1_data = $urandom; rs2_data = $urandom;
            dataEX = $urandom; dataMEM = $urandom; dataWB = $urandom;
            forwardingRs1EX  = 1'($urandom_range(0, 1));
            forwardingRs2EX  = 1'($urandom_range(0, 1));
            forwardingRs1MEM = 1'($urandom_range(0, 1));
            forwardingRs2MEM = 1'($urandom_range(0, 1));
            forwardingRs1WB  = 1'($urandom_range(0, 1));
            forwardingRs2WB  = 1'($urandom_range(0, 1));
            ea = (rs1 == 5'd0) ? 32'h0 : forwardingRs1EX ? dataEX :
                 forwardingRs1MEM ? dataMEM : forwardingRs1WB ? dataWB : rs1_data;
            eb = (rs2 == 5'd0) ? 32'h0 : forwardingRs2EX ? dataEX :
                 forwardingRs2MEM ? dataMEM : forwardingRs2WB ? dataWB : rs2_data;
            expQ.push_back(mkExp(1'b1, EscReg_in, 1'b0, rd_in, ea, eb, imm_in));
            step();
            expV = expQ.pop_front();
            nChecks++;
            if (obs !== expV) begin
                nFail++; $display("FAIL random_%0d: got %h expected %h", k, obs, expV);
            end else $display("txn random %0d opA=%h opB=%h", k, opA, opB);
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        test_reset();
        test_priority();
        test_x0_mask();
        test_load_use();
        test_back_to_back();
        test_flush();
        test_stale_flags();
        test_counters();
        test_reset_mid_stall();
        test_random();
        nChecks++;
        if (expQ.size() != 0) begin
            nFail++; $display("FAIL scoreboard_drain: got %0d entries expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with EX-operand selection. It sits directly downstream of the forwarding unit and consumes its six forwarding flags. Each cycle it picks each source operand from the register-file read data or from the EX, MEM or WB result buses, and registers the selected operands with control into the EX stage. It detects load-use hazards, stalls ID for one cycle and injects a bubble; branch flushes also inject a bubble.

## Interface
Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register-address width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- valid_in  in  1  ID holds a real instruction
- flush_in  in  1  taken branch/jump; kill the ID instruction
- rs1, rs2  in  REG_AW  ID source registers
- rd_in  in  REG_AW  ID destination
- EscReg_in  in  1  register write enable, active-low (0 = write)
- MemLe_in  in  1  ID instruction is a load
- rs1_data, rs2_data  in  XLEN  register-file read data
- imm_in  in  XLEN  decoded immediate
- forwardingRs1EX, forwardingRs2EX, forwardingRs1MEM, forwardingRs2MEM, forwardingRs1WB, forwardingRs2WB  in  1  flags from the forwarding unit
- dataEX  in  XLEN  ALU result of the instruction currently in EX
- dataMEM  in  XLEN  result in MEM (load data already resolved)
- dataWB  in  XLEN  write-back value
- stall_out  out  1  combinational; hold PC and IF/ID this cycle
- valid_out  out  1  EX holds a real instruction
- opA, opB  out  XLEN  registered selected operands
- imm_out  out  XLEN  registered immediate
- rd_out  out  REG_AW  registered destination
- EscReg_out  out  1  registered write enable, active-low
- MemLe_out  out  1  registered load flag (EX is a load)

## Operation
- Operand select, per operand, priority EX > MEM > WB > register file.
- If rsN == 0, the operand is forced to 0, ignoring all flags. The forwarding unit does not mask x0.
- Load-use condition is `hazard = valid_in & MemLe_out & valid_out & ((forwardingRs1EX & rs1≠0) | (forwardingRs2EX & rs2≠0))`.
- stall_out = hazard & !flush_in.
- Register update, in priority order:
  - rst: load the reset bubble.
  - flush_in: load a bubble.
  - hazard: load a bubble.
  - otherwise, when valid_in = 1: load the selected operands and ID control.
  - otherwise: load a bubble.
- Bubble: valid_out = 0, EscReg_out = 1, MemLe_out = 0, rd_out = 0, opA = opB = imm_out = 0.
- A bubble has EscReg_out = 1, so the forwarding unit raises no EX flags against it. The stall therefore clears on the following cycle with no extra state.
- During a stall, upstream holds, so the same ID instruction is presented again. On the next cycle its dependency is in MEM and is taken from dataMEM.

## Timing
- Reset values: valid_out = 0, EscReg_out = 1, MemLe_out = 0, all other outputs 0, stall_out = 0.
- Latency is 1 cycle from ID inputs to registered outputs.
- stall_out is combinational in the same cycle. It depends only on current inputs and the registered EX state.
- A load-use hazard costs exactly one bubble cycle. Back-to-back dependent loads each cost one bubble.
- Simultaneous flush_in and hazard: flush wins, stall_out = 0, one bubble.
- rst asserted mid-stall: the register loads the reset bubble on that edge. stall_out may still be high combinationally in that cycle; upstream reset dominates.
- valid_in = 0 with stale flags: no stall, bubble loaded.

## Configuration
- ID_EX_STALL_CNT_EN defined:
  - Adds output stall_cnt (32 bits), the number of cycles with stall_out = 1.
  - Adds output flush_cnt (32 bits), the number of cycles with flush_in & valid_in = 1.
  - Both are cleared by rst and wrap from 2^32−1 to 0.
- Not defined: neither port nor the counters exist, and behaviour is otherwise identical.

## Structure
- Shared package pipe_pkg holds XLEN, REG_AW, an ex_ctrl_t struct {valid, EscReg, MemLe, rd} and the BUBBLE_CTRL constant.
- One sub-module, operand_mux, instantiated twice (rs1, rs2). Its inputs are the rs index, register-file data, the three flags and the three data buses; it outputs the selected operand, including the x0 masking.

## Test plan
- Reset:
  - Stimulus: rst = 1 for 2 cycles, then release with valid_in = 0.
  - Required: valid_out = 0, EscReg_out = 1, stall_out = 0, opA = opB = 0.
- Priority:
  - Stimulus: rs1 = 5; all three rs1 flags = 1; dataEX = 0x11, dataMEM = 0x22, dataWB = 0x33.
  - Required: opA = 0x11 next cycle.
  - Stimulus, same setup with only the MEM and WB flags = 1.
  - Required: opA = 0x22.
- x0 masking:
  - Stimulus: rs2 = 0; forwardingRs2EX = 1; dataEX = 0xDEAD; rs2_data = 0x5.
  - Required: opB = 0.
- Load-use:
  - Stimulus: a load to x7 is in EX (MemLe_out = 1); ID has rs1 = 7 with forwardingRs1EX = 1.
  - Required: stall_out = 1 for one cycle and a bubble registered.
  - Stimulus, next cycle: forwardingRs1MEM = 1, dataMEM = 0xABCD.
  - Required: opA = 0xABCD, valid_out = 1.
- Flush during hazard:
  - Stimulus: the load-use setup above plus flush_in = 1.
  - Required: stall_out = 0, bubble registered, and the following instruction enters normally.
- Counter (ID_EX_STALL_CNT_EN):
  - Stimulus: 3 load-use events and 2 flushes.
  - Required: stall_cnt = 3, flush_cnt = 2.
  - Stimulus: rst.
  - Required: both counters 0.
